// File: rtl/ocs_slot_switch.sv
// Behavioural optical circuit switch: per-slot rotation of ToR serial lanes,
// with a dark reconfiguration window inserted on every slot change.
module ocs_slot_switch #(
    parameter int P_PORT_NUM     = 8,
    parameter int P_SLOT0_OFFSET = 1,
    parameter int P_SLOT1_OFFSET = 3,
    parameter int P_CONFIG_DELAY = 125
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_slot_id,
    input  logic [P_PORT_NUM-1:0] i_tor_txp,
    input  logic [P_PORT_NUM-1:0] i_tor_txn,
    output logic [P_PORT_NUM-1:0] o_tor_rxp,
    output logic [P_PORT_NUM-1:0] o_tor_rxn,
    output logic                  o_link_up,
    output logic                  o_cfg_slot
);

    localparam int OFF0 = P_SLOT0_OFFSET % P_PORT_NUM;
    localparam int OFF1 = P_SLOT1_OFFSET % P_PORT_NUM;
    localparam logic HAS_WIN = (P_CONFIG_DELAY != 0) ? 1'b1 : 1'b0;
    localparam logic [15:0] LAST_CNT = 16'(P_CONFIG_DELAY - 1);

    logic                  s1_r;
    logic                  s2_r;
    logic                  cfg_slot_r;
    logic                  blank_r;
    logic [15:0]           cnt_r;
    logic [P_PORT_NUM-1:0] map0_rxp_s;
    logic [P_PORT_NUM-1:0] map0_rxn_s;
    logic [P_PORT_NUM-1:0] map1_rxp_s;
    logic [P_PORT_NUM-1:0] map1_rxn_s;
    logic [P_PORT_NUM-1:0] rxp_s;
    logic [P_PORT_NUM-1:0] rxn_s;

    // Two-flop synchroniser for the controller's asynchronous slot id.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= i_slot_id;
            s2_r <= s1_r;
        end
    end

    // Slot load and dark-window timer; a new slot always restarts the window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_slot_r <= 1'b0;
            blank_r    <= 1'b1;
            cnt_r      <= 16'd0;
        end else if (s2_r != cfg_slot_r) begin
            cfg_slot_r <= s2_r;
            blank_r    <= HAS_WIN;
            cnt_r      <= 16'd0;
        end else if (blank_r) begin
            if (!HAS_WIN || (cnt_r == LAST_CNT)) begin
                blank_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Both candidate rotations are fixed wiring; receiver j listens to (j+off) mod N.
    for (genvar j = 0; j < P_PORT_NUM; j++) begin : g_port
        localparam int SRC0 = (j + OFF0) % P_PORT_NUM;
        localparam int SRC1 = (j + OFF1) % P_PORT_NUM;
        assign map0_rxp_s[j] = i_tor_txp[SRC0];
        assign map0_rxn_s[j] = i_tor_txn[SRC0];
        assign map1_rxp_s[j] = i_tor_txp[SRC1];
        assign map1_rxn_s[j] = i_tor_txn[SRC1];
    end

    // Combinational lane select; dark state drives a static idle (p=0, n=1).
    always_comb begin
        rxp_s = {P_PORT_NUM{1'b0}};
        rxn_s = {P_PORT_NUM{1'b1}};
        if (blank_r) begin
            rxp_s = {P_PORT_NUM{1'b0}};
            rxn_s = {P_PORT_NUM{1'b1}};
        end else if (cfg_slot_r) begin
            rxp_s = map1_rxp_s;
            rxn_s = map1_rxn_s;
        end else begin
            rxp_s = map0_rxp_s;
            rxn_s = map0_rxn_s;
        end
    end

    assign o_tor_rxp  = rxp_s;
    assign o_tor_rxn  = rxn_s;
    assign o_link_up  = ~blank_r;
    assign o_cfg_slot = cfg_slot_r;

endmodule

// File: tb/tb_ocs_slot_switch.sv
// Directed bench for ocs_slot_switch: OCS0-style, OCS1-style and zero-delay instances.
module tb_ocs_slot_switch;

    logic       clk;
    logic       rst_n;
    logic       slot0, slot1, slotz;
    logic [7:0] txp, txn;
    logic [7:0] rxp0, rxn0, rxp1, rxn1, rxpz, rxnz;
    logic       up0, up1, upz;
    logic       cfg0, cfg1, cfgz;
    int         total;
    int         passed;

    ocs_slot_switch #(.P_PORT_NUM(8), .P_SLOT0_OFFSET(1), .P_SLOT1_OFFSET(3), .P_CONFIG_DELAY(125)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_slot_id(slot0), .i_tor_txp(txp), .i_tor_txn(txn),
        .o_tor_rxp(rxp0), .o_tor_rxn(rxn0), .o_link_up(up0), .o_cfg_slot(cfg0));

    ocs_slot_switch #(.P_PORT_NUM(8), .P_SLOT0_OFFSET(2), .P_SLOT1_OFFSET(4), .P_CONFIG_DELAY(125)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_slot_id(slot1), .i_tor_txp(txp), .i_tor_txn(txn),
        .o_tor_rxp(rxp1), .o_tor_rxn(rxn1), .o_link_up(up1), .o_cfg_slot(cfg1));

    ocs_slot_switch #(.P_PORT_NUM(8), .P_SLOT0_OFFSET(1), .P_SLOT1_OFFSET(3), .P_CONFIG_DELAY(0)) dutz (
        .i_clk(clk), .i_rst_n(rst_n), .i_slot_id(slotz), .i_tor_txp(txp), .i_tor_txn(txn),
        .o_tor_rxp(rxpz), .o_tor_rxn(rxnz), .o_link_up(upz), .o_cfg_slot(cfgz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        slot0  = 1'b0;
        slot1  = 1'b0;
        slotz  = 1'b0;
        txp    = 8'h00;
        txn    = 8'hFF;
        tick(2);
        check("reset_up0", {7'd0, up0}, 8'h00);
        check("reset_rxp0", rxp0, 8'h00);
        check("reset_rxn0", rxn0, 8'hFF);
        rst_n = 1'b1;
        txp = 8'b0000_0010;
        txn = 8'b1111_1101;
        tick(1);
        check("z_up_first_edge", {7'd0, upz}, 8'h01);
        check("z_map_slot0", rxpz, 8'h01);
        check("dark_edge1_up0", {7'd0, up0}, 8'h00);
        tick(123);
        check("dark_edge124_up0", {7'd0, up0}, 8'h00);
        check("dark_edge124_up1", {7'd0, up1}, 8'h00);
        check("dark_edge124_rxp0", rxp0, 8'h00);
        check("dark_edge124_rxn0", rxn0, 8'hFF);
        tick(1);
        check("up_edge125_up0", {7'd0, up0}, 8'h01);
        check("up_edge125_cfg0", {7'd0, cfg0}, 8'h00);
        check("ocs0_s0_rxp", rxp0, 8'h01);
        check("ocs0_s0_rxn", rxn0, 8'hFE);
        check("ocs1_s0_rxp", rxp1, 8'h80);
        check("ocs1_s0_rxn", rxn1, 8'h7F);

        // OCS0 slot 0 -> 1
        slot0 = 1'b1;
        tick(2);
        check("ocs0_tog_edge2_up", {7'd0, up0}, 8'h01);
        tick(1);
        check("ocs0_tog_edge3_up", {7'd0, up0}, 8'h00);
        check("ocs0_tog_edge3_cfg", {7'd0, cfg0}, 8'h01);
        tick(124);
        check("ocs0_win_end_minus1", {7'd0, up0}, 8'h00);
        tick(1);
        check("ocs0_win_end_up", {7'd0, up0}, 8'h01);
        txp = 8'h08;
        txn = 8'hF7;
        #1;
        check("ocs0_s1_rxp", rxp0, 8'h01);
        check("ocs0_s1_rxn", rxn0, 8'hFE);
        check("ocs0_s1_cfg", {7'd0, cfg0}, 8'h01);

        // OCS1 slot 0 -> 1
        slot1 = 1'b1;
        tick(128);
        txp = 8'h01;
        txn = 8'hFE;
        #1;
        check("ocs1_s1_up", {7'd0, up1}, 8'h01);
        check("ocs1_s1_rxp", rxp1, 8'h10);
        check("ocs1_s1_rxn", rxn1, 8'hEF);

        // OCS1 window restart: 1 -> 0, then back to 1 50 cycles into the window
        slot1 = 1'b0;
        tick(3);
        check("restart_first_dark", {7'd0, up1}, 8'h00);
        check("restart_first_cfg", {7'd0, cfg1}, 8'h00);
        tick(50);
        slot1 = 1'b1;
        tick(2);
        check("restart_mid_up", {7'd0, up1}, 8'h00);
        check("restart_mid_cfg", {7'd0, cfg1}, 8'h00);
        tick(1);
        check("restart_reload_cfg", {7'd0, cfg1}, 8'h01);
        tick(124);
        check("restart_end_minus1", {7'd0, up1}, 8'h00);
        tick(1);
        check("restart_end_up", {7'd0, up1}, 8'h01);
        check("restart_final_rxp", rxp1, 8'h10);

        // Zero-delay instance: mapping flips at the third edge, link never drops
        txp = 8'h08;
        txn = 8'hF7;
        slotz = 1'b1;
        tick(1);
        check("z_tog_edge1_up", {7'd0, upz}, 8'h01);
        tick(1);
        check("z_tog_edge2_up", {7'd0, upz}, 8'h01);
        check("z_tog_edge2_rxp", rxpz, 8'h04);
        tick(1);
        check("z_tog_edge3_up", {7'd0, upz}, 8'h01);
        check("z_tog_edge3_cfg", {7'd0, cfgz}, 8'h01);
        check("z_tog_edge3_rxp", rxpz, 8'h01);
        check("z_tog_edge3_rxn", rxnz, 8'hFE);

        // Asynchronous reset while connected
        rst_n = 1'b0;
        #1;
        check("async_rst_up0", {7'd0, up0}, 8'h00);
        check("async_rst_cfg0", {7'd0, cfg0}, 8'h00);
        check("async_rst_rxp0", rxp0, 8'h00);
        check("async_rst_rxn0", rxn0, 8'hFF);
        check("async_rst_upz", {7'd0, upz}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ocs_slot_switch.md
Name: ocs_slot_switch

Overview:
- Behavioural model of one optical circuit switch (OCS) fabric with 8 ports, used in the SSRNet system simulation.
- Each port pair is one ToR serial TX lane in and one ToR serial RX lane out.
- The per-slot permutation is a rotation selected by the controller's slot id.
- A dark reconfiguration window is inserted on every slot change.
- OCS0_module and OCS1_module are thin wrappers of this block, differing only in the offset parameters they set.

Parameters:
- P_PORT_NUM, 8: number of ToR ports.
- P_SLOT0_OFFSET, 1: rotation offset while slot 0 is active. OCS0_module uses 1; OCS1_module uses 2.
- P_SLOT1_OFFSET, 3: rotation offset while slot 1 is active. OCS0_module uses 3; OCS1_module uses 4.
- P_CONFIG_DELAY, 125: length of the dark window in i_clk cycles. 0 means no dark window.

Ports:
- i_clk  in  1  model clock; domain of slot sync and reconfig timer.
- i_rst_n  in  1  asynchronous active-low reset.
- i_slot_id  in  1  current slot id from the OCS controller; asynchronous to i_clk.
- i_tor_txp  in  P_PORT_NUM  ToR serial TX, positive leg; bit k belongs to ToR k.
- i_tor_txn  in  P_PORT_NUM  ToR serial TX, negative leg.
- o_tor_rxp  out  P_PORT_NUM  serial RX towards ToR k, positive leg.
- o_tor_rxn  out  P_PORT_NUM  serial RX towards ToR k, negative leg.
- o_link_up  out  1  1 = circuits connected; 0 = dark/reconfiguring.
- o_cfg_slot  out  1  slot whose permutation is loaded.

Behaviour:
- Slot synchroniser: i_slot_id passes through a two-flop synchroniser, r_s1 then r_s2. Both reset to 0.
- State registers:
  - r_cfg_slot, reset 0.
  - r_blank, reset 1.
  - r_cnt, 16-bit, reset 0.
- Slot change: on a clock edge where r_s2 != r_cfg_slot:
  - r_cfg_slot <= r_s2, r_blank <= 1, r_cnt <= 0.
  - This applies whether or not a dark window is already in progress; a change mid-window restarts the window.
- Window countdown: otherwise, while r_blank = 1:
  - If r_cnt == P_CONFIG_DELAY-1, then r_blank <= 0.
  - Else r_cnt <= r_cnt + 1.
- Dark window length: exactly P_CONFIG_DELAY cycles after the edge that loads the new slot.
- P_CONFIG_DELAY = 0: r_blank is never set and the new mapping applies from the loading edge. After reset it clears on the first edge.
- After reset release: outputs stay dark for P_CONFIG_DELAY cycles, then the slot-0 mapping connects. If i_slot_id is 1, the change is detected 2 cycles after release and the window restarts.
- Offset: off = (r_cfg_slot == 0) ? P_SLOT0_OFFSET : P_SLOT1_OFFSET, taken modulo P_PORT_NUM.
- Data path is combinational from i_tor_tx* to o_tor_rx*, with no sampling of serial data. Only the control is registered.
- Connected (r_blank = 0): for each j, src = (j + off) mod P_PORT_NUM.
  - o_tor_rxp[j] = i_tor_txp[src].
  - o_tor_rxn[j] = i_tor_txn[src].
- Dark (r_blank = 1): every o_tor_rxp[j] = 0 and every o_tor_rxn[j] = 1 (static idle; loss of signal at receivers).
- Offset 0 is legal and gives a loopback; the wrappers do not use it.
- o_link_up = ~r_blank. o_cfg_slot = r_cfg_slot.
- Reset mid-operation: all registers return to reset values immediately and outputs go dark asynchronously.
- No other state; the mapping is the same for every port (a pure rotation).

Test Plan:
- Reset, i_slot_id=0, P_CONFIG_DELAY=125:
  - o_link_up stays 0 and all rxp=0/rxn=1 for 125 cycles after release.
  - Then o_link_up=1 and o_cfg_slot=0.
- OCS0 wrapper, slot 0, drive i_tor_txp = 8'b0000_0010:
  - o_tor_rxp = 8'b0000_0001 (rx0 from tx1); o_tor_rxn mirrors i_tor_txn with the same rotation.
- Toggle i_slot_id 0->1:
  - o_link_up falls 3 edges later, stays low for exactly 125 cycles.
  - Then i_tor_txp = 8'h08 gives o_tor_rxp = 8'h01 (offset 3); o_cfg_slot=1.
- OCS1 wrapper, slot 1, i_tor_txp = 8'h01:
  - o_tor_rxp = 8'h10 (rx4 from tx0, offset 4).
- Toggle i_slot_id again 50 cycles into a dark window:
  - The window restarts: total dark time is 50 + 3 + 125 cycles.
  - The final mapping matches the last slot.
- P_CONFIG_DELAY=0, slot toggle:
  - o_link_up never falls after the first edge.
  - The mapping switches 3 edges after the input toggle.
- Assert i_rst_n low while connected:
  - Outputs go dark immediately, without waiting for a clock edge.
